// File: rtl/spi_slave_param.sv
// -----------------------------------------------------------------------------
// spi_slave_param
// Parameterised SPI slave with a one-entry transmit holding register and a
// receive FIFO. All SPI pins are oversampled in the clk domain; the serial
// clock is recovered by edge detection on the synchronised sck.
//
// Optional feature macro: SPI_SLAVE_LSB_FIRST_EN
//   defined   -> extra input lsb_first selects LSB-first order (both directions)
//   undefined -> MSB-first only, no lsb_first port
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   ss, sck, mosi         SPI pins (asynchronous, ss active-low)
//   miso                  SPI data out, always driven, 1 while deselected
//   cpol, cpha            SPI mode, latched while deselected
//   tx_data/valid/ready   transmit word handshake (one holding entry)
//   rx_data/valid/ready   receive word handshake (FIFO head)
//   rx_overrun            one-cycle pulse: received word dropped, FIFO full
//   tx_underrun           one-cycle pulse: all-ones word sent, no tx data
//   busy                  synchronised ss is low
// -----------------------------------------------------------------------------
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int AW    = $clog2(RX_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(RX_DEPTH);

  // Next value of the transmit shifter after one bit has been sent.
  function automatic logic [DATA_W-1:0] tx_shift_fn(input logic [DATA_W-1:0] v,
                                                    input logic lsb);
    logic [DATA_W-1:0] r;
    if (lsb) r = {1'b1, v[DATA_W-1:1]};
    else     r = {v[DATA_W-2:0], 1'b1};
    return r;
  endfunction

  // Bit currently presented on miso.
  function automatic logic tx_bit_fn(input logic [DATA_W-1:0] v, input logic lsb);
    logic r;
    if (lsb) r = v[0];
    else     r = v[DATA_W-1];
    return r;
  endfunction

  // Receive shifter after assembling one sampled bit.
  function automatic logic [DATA_W-1:0] rx_shift_fn(input logic [DATA_W-1:0] v,
                                                    input logic b, input logic lsb);
    logic [DATA_W-1:0] r;
    if (lsb) r = {b, v[DATA_W-1:1]};
    else     r = {v[DATA_W-2:0], b};
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] ss_sync_r, sck_sync_r, mosi_sync_r, vld_sync_r;
  logic ss_s, ss_nxt_s, sck_s, mosi_s, sync_vld_s;
  logic sck_prev_r, ss_prev_r, armed_r, frame_act_r;
  logic cpol_r, cpha_r, lsb_sel_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [DATA_W-1:0] tx_shift_r, tx_shift_nxt_s, rx_shift_r;
  logic hold_full_r, hold_take_s;
  logic [DATA_W-1:0] hold_data_r;
  logic ur_pend_r, underrun_s;
  logic lead_s, trail_s, in_word_s, sample_s, shift_s, fall_s, done_s;
  logic push_r, pop_s, full_s, wr_ok_s;
  logic [DATA_W-1:0] mem_r [RX_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] count_r;
  logic miso_r, busy_r, rx_overrun_r, tx_underrun_r;

  // Synchronisers; vld_sync_r marks when reset fill values have flushed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      vld_sync_r  <= {SYNC_STAGES{1'b0}};
    end else begin
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      vld_sync_r  <= {vld_sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ss_s       = ss_sync_r[SYNC_STAGES-1];
  assign ss_nxt_s   = ss_sync_r[SYNC_STAGES-2];
  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sync_vld_s = vld_sync_r[SYNC_STAGES-1];

  // Mode latch: only follows the mode inputs while deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_r <= 1'b0;
      cpha_r <= 1'b0;
    end else if (ss_s) begin
      cpol_r <= cpol;
      cpha_r <= cpha;
    end else begin
      cpol_r <= cpol_r;
      cpha_r <= cpha_r;
    end
  end

`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_first_r;
  // Bit-order latch, same timing as the mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lsb_first_r <= 1'b0;
    else if (ss_s) lsb_first_r <= lsb_first;
    else           lsb_first_r <= lsb_first_r;
  end
  assign lsb_sel_s = lsb_first_r;
`else
  assign lsb_sel_s = 1'b0;
`endif

  // Edge classification relative to the latched idle level.
  assign lead_s    = (sck_s != cpol_r) && (sck_prev_r == cpol_r);
  assign trail_s   = (sck_s == cpol_r) && (sck_prev_r != cpol_r);
  assign in_word_s = frame_act_r && !ss_s;
  assign sample_s  = in_word_s && (cpha_r ? trail_s : lead_s);
  // The first shift edge of a word is skipped: that bit was presented on load.
  assign shift_s   = in_word_s && (cpha_r ? lead_s : trail_s) && (bit_cnt_r != {CNT_W{1'b0}});
  assign done_s    = sample_s && (bit_cnt_r == LAST_BIT);
  // A falling ss only starts a frame once ss has genuinely been seen high.
  assign fall_s    = armed_r && ss_prev_r && !ss_s;

  // Transmit shifter next state, holding-register take and underrun detection.
  // A back-to-back word that finds no tx data is loaded with all-ones at once,
  // but the underrun is only reported when the master starts clocking that
  // word, so a frame that simply ends after its last word raises no error.
  always_comb begin
    tx_shift_nxt_s = tx_shift_r;
    hold_take_s    = 1'b0;
    underrun_s     = 1'b0;
    if (fall_s || done_s) begin
      if (hold_full_r) begin
        tx_shift_nxt_s = hold_data_r;
        hold_take_s    = 1'b1;
      end else begin
        tx_shift_nxt_s = {DATA_W{1'b1}};
        underrun_s     = fall_s;
      end
    end else if (shift_s) begin
      tx_shift_nxt_s = tx_shift_fn(tx_shift_r, lsb_sel_s);
    end else begin
      tx_shift_nxt_s = tx_shift_r;
    end
    if (sample_s && (bit_cnt_r == {CNT_W{1'b0}}) && ur_pend_r) begin
      underrun_s = 1'b1;
    end else begin
      underrun_s = underrun_s;
    end
  end

  // Frame tracking, bit counter and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev_r  <= 1'b0;
      ss_prev_r   <= 1'b1;
      armed_r     <= 1'b0;
      frame_act_r <= 1'b0;
      bit_cnt_r   <= {CNT_W{1'b0}};
      tx_shift_r  <= {DATA_W{1'b0}};
      rx_shift_r  <= {DATA_W{1'b0}};
      ur_pend_r   <= 1'b0;
      push_r      <= 1'b0;
    end else begin
      sck_prev_r <= sck_s;
      ss_prev_r  <= ss_s;
      armed_r    <= armed_r | (sync_vld_s & ss_s);
      tx_shift_r <= tx_shift_nxt_s;
      push_r     <= done_s;
      if (sample_s) rx_shift_r <= rx_shift_fn(rx_shift_r, mosi_s, lsb_sel_s);
      else          rx_shift_r <= rx_shift_r;
      // Deselect discards any partial word.
      if (ss_s) begin
        frame_act_r <= 1'b0;
        bit_cnt_r   <= {CNT_W{1'b0}};
        ur_pend_r   <= 1'b0;
      end else begin
        frame_act_r <= frame_act_r | fall_s;
        if (done_s)        bit_cnt_r <= {CNT_W{1'b0}};
        else if (sample_s) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        else               bit_cnt_r <= bit_cnt_r;
        if (done_s)        ur_pend_r <= ~hold_full_r;
        else if (sample_s) ur_pend_r <= 1'b0;
        else               ur_pend_r <= ur_pend_r;
      end
    end
  end

  // Transmit holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_r <= 1'b0;
      hold_data_r <= {DATA_W{1'b0}};
    end else if (hold_take_s) begin
      hold_full_r <= 1'b0;
    end else if (tx_valid && !hold_full_r) begin
      hold_full_r <= 1'b1;
      hold_data_r <= tx_data;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  assign pop_s   = (count_r != {(AW + 1){1'b0}}) && rx_ready;
  assign full_s  = (count_r == FIFO_FULL);
  assign wr_ok_s = push_r && (!full_s || pop_s);

  // Receive FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= rx_shift_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      else       rd_ptr_r <= rd_ptr_r;
      case ({wr_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered pin/status outputs, computed from next-state values so they
  // line up with the internal state without an extra cycle of lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_r        <= 1'b1;
      busy_r        <= 1'b0;
      rx_overrun_r  <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      miso_r        <= ss_nxt_s | tx_bit_fn(tx_shift_nxt_s, lsb_sel_s);
      busy_r        <= ~ss_nxt_s;
      rx_overrun_r  <= push_r & full_s & ~pop_s;
      tx_underrun_r <= underrun_s;
    end
  end

  assign miso        = miso_r;
  assign busy        = busy_r;
  assign rx_overrun  = rx_overrun_r;
  assign tx_underrun = tx_underrun_r;
  assign tx_ready    = ~hold_full_r;
  assign rx_valid    = (count_r != {(AW + 1){1'b0}});
  assign rx_data     = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_spi_slave_param.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_param
// Directed bench for spi_slave_param (DATA_W=8, RX_DEPTH=4, SYNC_STAGES=2).
// A behavioural SPI master drives the pins at clk/16; expected words are
// hand-computed constants. Error pulses are counted by a small monitor.
// -----------------------------------------------------------------------------
module tb_spi_slave_param;

  localparam int H = 80; // SPI half period in ns (clk period 10 ns)

  logic clk = 1'b0;
  logic rst_n, ss, sck, mosi, miso, cpol, cpha;
  logic [7:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_ready, rx_overrun, tx_underrun, busy;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_first;
`endif

  int tests = 0;
  int fails = 0;
  int ov_cnt = 0;
  int ur_cnt = 0;
  int ov0, ur0;
  logic [7:0] mi, mi2;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .RX_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso),
    .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
  );

  // Count cycles on which each error pulse is high.
  always @(posedge clk) begin
    if (rx_overrun === 1'b1)  ov_cnt <= ov_cnt + 1;
    if (tx_underrun === 1'b1) ur_cnt <= ur_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Master: clock nbits bits of mo, return bits seen on miso.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input logic lsb,
                          output logic [7:0] got);
    int idx;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[idx]; #(H);
        got[idx] = miso; sck = ~cpol; #(H);
        sck = cpol;
      end else begin
        sck = ~cpol; mosi = mo[idx]; #(H);
        got[idx] = miso; sck = cpol; #(H);
      end
    end
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    #(2*H);
  endtask

  task automatic frame_end();
    #(H);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p; cpha = h; sck = p;
    repeat (6) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
  endtask

  task automatic pop();
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"},    rx_valid,    1'b0);
    check({tag, "_rx_data"},     rx_data,     8'h00);
    check({tag, "_tx_ready"},    tx_ready,    1'b1);
    check({tag, "_rx_overrun"},  rx_overrun,  1'b0);
    check({tag, "_tx_underrun"}, tx_underrun, 1'b0);
    check({tag, "_busy"},        busy,        1'b0);
    check({tag, "_miso"},        miso,        1'b1);
  endtask

  initial begin
    logic [1:0] mv;
    rst_n = 1'b1; ss = 1'b1; sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Mode 0: tx 0xA5 preloaded, master sends 0x3C.
    load_tx(8'hA5);
    check("tx_ready_loaded", tx_ready, 1'b0);
    ov0 = ov_cnt; ur0 = ur_cnt;
    frame_begin();
    check("busy_selected", busy, 1'b1);
    spi_bits(8'h3C, 8, 1'b0, mi);
    frame_end();
    check("m0_miso_word", mi, 8'hA5);
    check("m0_rx_valid", rx_valid, 1'b1);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_no_overrun", ov_cnt - ov0, 0);
    check("m0_no_underrun", ur_cnt - ur0, 0);
    check("busy_idle", busy, 1'b0);
    check("miso_idle", miso, 1'b1);
    check("tx_ready_taken", tx_ready, 1'b1);
    pop();
    check("m0_rx_empty", rx_valid, 1'b0);

    // Modes 1..3: master 0x96, tx 0x69.
    for (int m = 1; m < 4; m++) begin
      mv = 2'(m);
      set_mode(mv[1], mv[0]);
      load_tx(8'h69);
      frame_begin();
      spi_bits(8'h96, 8, 1'b0, mi);
      frame_end();
      check($sformatf("mode%0d_miso", m), mi, 8'h69);
      check($sformatf("mode%0d_rx_data", m), rx_data, 8'h96);
      check($sformatf("mode%0d_rx_valid", m), rx_valid, 1'b1);
      pop();
    end

    // Overrun: five words into a 4-deep FIFO with rx_ready low.
    set_mode(1'b0, 1'b0);
    ov0 = ov_cnt;
    frame_begin();
    for (int w = 1; w <= 5; w++) spi_bits(8'(w), 8, 1'b0, mi);
    frame_end();
    check("ovr_pulses", ov_cnt - ov0, 1);
    for (int w = 1; w <= 4; w++) begin
      check($sformatf("ovr_drain%0d", w), rx_data, 32'(w));
      pop();
    end
    check("ovr_drained", rx_valid, 1'b0);

    // Underrun: two-word frame with nothing loaded.
    ur0 = ur_cnt;
    frame_begin();
    spi_bits(8'h11, 8, 1'b0, mi);
    spi_bits(8'h22, 8, 1'b0, mi2);
    frame_end();
    check("udr_pulses", ur_cnt - ur0, 2);
    check("udr_miso_w0", mi, 8'hFF);
    check("udr_miso_w1", mi2, 8'hFF);
    check("udr_rx0", rx_data, 8'h11);
    pop();
    check("udr_rx1", rx_data, 8'h22);
    pop();

    // Abort after 5 bits, then a full 0xC3 word.
    load_tx(8'h81);
    ur0 = ur_cnt;
    frame_begin();
    spi_bits(8'hF0, 5, 1'b0, mi);
    frame_end();
    check("abort_no_push", rx_valid, 1'b0);
    check("abort_no_underrun", ur_cnt - ur0, 0);
    load_tx(8'h42);
    frame_begin();
    spi_bits(8'hC3, 8, 1'b0, mi);
    frame_end();
    check("abort_next_rx", rx_data, 8'hC3);
    check("abort_next_miso", mi, 8'h42);
    pop();
    check("abort_single_word", rx_valid, 1'b0);

    // Reset pulsed mid-word with a word queued and tx loaded.
    load_tx(8'h5A);
    frame_begin();
    spi_bits(8'h77, 8, 1'b0, mi);
    frame_end();
    load_tx(8'h33);
    check("pre_rst_rx_valid", rx_valid, 1'b1);
    check("pre_rst_tx_ready", tx_ready, 1'b0);
    frame_begin();
    spi_bits(8'hFF, 3, 1'b0, mi);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    #9 rst_n = 1'b1;
    ur0 = ur_cnt;
    spi_bits(8'hAA, 8, 1'b0, mi);
    #(H);
    check("rst_lowss_no_push", rx_valid, 1'b0);
    check("rst_lowss_no_start", ur_cnt - ur0, 0);
    check("rst_lowss_busy", busy, 1'b1);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    load_tx(8'h3C);
    frame_begin();
    spi_bits(8'hE7, 8, 1'b0, mi);
    frame_end();
    check("recover_rx", rx_data, 8'hE7);
    check("recover_miso", mi, 8'h3C);
    pop();

`ifdef SPI_SLAVE_LSB_FIRST_EN
    // LSB first: master sends 0x01, slave returns 0x6D (bit 0 = 1 first).
    lsb_first = 1'b1;
    repeat (6) @(negedge clk);
    load_tx(8'h6D);
    frame_begin();
    spi_bits(8'h01, 8, 1'b1, mi);
    frame_end();
    check("lsb_rx", rx_data, 8'h01);
    check("lsb_first_bit", mi[0], 1'b1);
    check("lsb_miso_word", mi, 8'h6D);
    pop();
    lsb_first = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
